// File: rtl/tb_check_pkg.sv
// Shared types for the end-of-test check controller: FSM states, mismatch record and
// the default answer-window base.
package tb_check_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    RUN,
    DRAIN,
    CMP_REG,
    CMP_MEM,
    DONE
  } state_t;

  localparam int MIS_W = 32;

  typedef struct packed {
    logic             is_mem;
    logic [15:0]      addr;
    logic [MIS_W-1:0] got;
    logic [MIS_W-1:0] exp;
  } mis_t;

  localparam int unsigned DEF_MEM_BASE = 32'h9000;

endpackage

// File: rtl/tb_check_ctrl_cmp_sweep.sv
// Address generator plus one-stage compare pipeline; entry i issued at cycle t is
// compared at t+1 and a mismatch is reported (registered) at t+2.
module cmp_sweep
  import tb_check_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter int          COUNT  = 32,
  parameter int unsigned BASE   = 0,
  parameter int unsigned STRIDE = 1,
  parameter int          AW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] gold_data,
  output logic            last,
  output logic            hit,
  output logic            mis_valid,
  output logic [AW-1:0]   mis_addr,
  output logic [XLEN-1:0] mis_got,
  output logic [XLEN-1:0] mis_exp
);

  localparam int IW = $clog2(COUNT + 1);

  logic [IW-1:0] idx;
  logic [AW-1:0] addr_cur;
  logic [AW-1:0] addr_hold;
  logic [AW-1:0] addr_p0;
  logic          issue;
  logic          vld_p0;

  // Address wraps at AW bits; outside an active issue the last address is held.
  assign last     = (idx == IW'(COUNT));
  assign issue    = en && !last;
  assign addr_cur = AW'(BASE + STRIDE * 32'(idx));
  assign addr     = issue ? addr_cur : addr_hold;
  assign hit      = vld_p0 && (rd_data != gold_data);

  // Stage p0: issued address waits one cycle for the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      addr_hold <= '0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= issue;
      if (issue) begin
        idx       <= idx + IW'(1);
        addr_hold <= addr_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) addr_p0 <= addr_cur;
  end

  // Stage p1: registered mismatch report.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_valid <= 1'b0;
      mis_addr  <= '0;
      mis_got   <= '0;
      mis_exp   <= '0;
    end else begin
      mis_valid <= hit;
      if (hit) begin
        mis_addr <= addr_p0;
        mis_got  <= rd_data;
        mis_exp  <= gold_data;
      end
    end
  end

endmodule

// File: rtl/tb_check_ctrl.sv
// End-of-test controller: CPU reset sequencing, run-cycle count with halt/timeout,
// drain, then register and answer-memory sweeps against golden data.
module tb_check_ctrl
  import tb_check_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          NUM_REGS     = 32,
  parameter int unsigned MEM_BASE     = DEF_MEM_BASE,
  parameter int          NUM_WORDS    = 1024,
  parameter int          RST_CYCLES   = 4,
  parameter int          DRAIN_CYCLES = 8,
  parameter int          MAX_CYCLES   = 1000000,
  parameter int          CNT_W        = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  output logic             cpu_rst,
  output logic [4:0]       reg_rd_addr,
  input  logic [XLEN-1:0]  reg_rd_data,
  input  logic [XLEN-1:0]  gold_reg_data,
  output logic [15:0]      mem_rd_addr,
  input  logic [XLEN-1:0]  mem_rd_data,
  input  logic [XLEN-1:0]  gold_mem_data,
  output logic             mis_valid,
  output logic             mis_is_mem,
  output logic [15:0]      mis_addr,
  output logic [XLEN-1:0]  mis_got,
  output logic [XLEN-1:0]  mis_exp,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] err_count,
  output logic             done,
  output logic             pass,
  output logic             timeout
);

  localparam int WAIT_W = 16;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              reg_last, reg_hit, reg_mis_valid;
  logic              mem_last, mem_hit, mem_mis_valid;
  logic [4:0]        reg_mis_addr;
  logic [15:0]       mem_mis_addr;
  logic [XLEN-1:0]   reg_mis_got, reg_mis_exp, mem_mis_got, mem_mis_exp;
  mis_t              mis_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      RST_HOLD: if (wait_cnt == WAIT_W'(RST_CYCLES - 1)) state_nxt = RUN;
      RUN: begin
        if (halt) state_nxt = DRAIN;
        else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) state_nxt = DONE;
      end
      DRAIN:    if (wait_cnt == WAIT_W'(DRAIN_CYCLES - 1)) state_nxt = CMP_REG;
      CMP_REG:  if (reg_last) state_nxt = CMP_MEM;
      CMP_MEM:  if (mem_last) state_nxt = DONE;
      DONE:     state_nxt = DONE;
      default:  state_nxt = RST_HOLD;
    endcase
  end

  // wait_cnt restarts on every state change and times RST_HOLD and DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RST_HOLD;
      wait_cnt    <= '0;
      cycle_count <= '0;
      err_count   <= '0;
      timeout     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + WAIT_W'(1);
      if (state == RUN && !halt && cycle_count != CNT_W'(MAX_CYCLES))
        cycle_count <= cycle_count + CNT_W'(1);
      if (state == RUN && state_nxt == DONE) timeout <= 1'b1;
      if (reg_hit || mem_hit) err_count <= sat_inc(err_count);
    end
  end

  assign cpu_rst = (state == RST_HOLD) || (state == DONE);
  assign done    = (state == DONE);
  assign pass    = done && (err_count == '0) && !timeout;

  cmp_sweep #(
    .XLEN(XLEN), .COUNT(NUM_REGS), .BASE(0), .STRIDE(1), .AW(5)
  ) u_reg_sweep (
    .clk(clk), .rst(rst), .en(state == CMP_REG),
    .addr(reg_rd_addr), .rd_data(reg_rd_data), .gold_data(gold_reg_data),
    .last(reg_last), .hit(reg_hit), .mis_valid(reg_mis_valid),
    .mis_addr(reg_mis_addr), .mis_got(reg_mis_got), .mis_exp(reg_mis_exp)
  );

  cmp_sweep #(
    .XLEN(XLEN), .COUNT(NUM_WORDS), .BASE(MEM_BASE), .STRIDE(4), .AW(16)
  ) u_mem_sweep (
    .clk(clk), .rst(rst), .en(state == CMP_MEM),
    .addr(mem_rd_addr), .rd_data(mem_rd_data), .gold_data(gold_mem_data),
    .last(mem_last), .hit(mem_hit), .mis_valid(mem_mis_valid),
    .mis_addr(mem_mis_addr), .mis_got(mem_mis_got), .mis_exp(mem_mis_exp)
  );

  // The two sweeps never report in the same cycle, so a simple priority mux suffices.
  always_comb begin
    mis_sel = '{is_mem: 1'b0, addr: 16'(reg_mis_addr),
                got: MIS_W'(reg_mis_got), exp: MIS_W'(reg_mis_exp)};
    if (mem_mis_valid)
      mis_sel = '{is_mem: 1'b1, addr: mem_mis_addr,
                  got: MIS_W'(mem_mis_got), exp: MIS_W'(mem_mis_exp)};
  end

  assign mis_valid  = reg_mis_valid | mem_mis_valid;
  assign mis_is_mem = mis_sel.is_mem;
  assign mis_addr   = mis_sel.addr;
  assign mis_got    = XLEN'(mis_sel.got);
  assign mis_exp    = XLEN'(mis_sel.exp);

endmodule

// File: tb/tb_tb_check_ctrl.sv
// Directed bench for tb_check_ctrl: default instance with memory models, a short-timeout
// instance and a narrow-counter instance for error-count saturation.
module tb_tb_check_ctrl;
  import tb_check_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main instance
  logic        rst = 1'b1, halt = 1'b0, cpu_rst;
  logic [4:0]  reg_rd_addr;
  logic [15:0] mem_rd_addr, mis_addr;
  logic [31:0] reg_rd_data, gold_reg_data, mem_rd_data, gold_mem_data, mis_got, mis_exp;
  logic        mis_valid, mis_is_mem, done, pass, timeout;
  logic [19:0] cycle_count, err_count;

  // Timeout instance (MAX_CYCLES=100)
  logic        rst_t = 1'b1, halt_t = 1'b0, cpu_rst_t;
  logic [4:0]  reg_rd_addr_t;
  logic [15:0] mem_rd_addr_t, mis_addr_t;
  logic [31:0] zero_t, mis_got_t, mis_exp_t;
  logic        mis_valid_t, mis_is_mem_t, done_t, pass_t, timeout_t;
  logic [19:0] cycle_count_t, err_count_t;

  // Saturation instance (CNT_W=3)
  logic        rst_s = 1'b1, halt_s = 1'b0, cpu_rst_s;
  logic [4:0]  reg_rd_addr_s;
  logic [15:0] mem_rd_addr_s, mis_addr_s;
  logic [31:0] one_s, zero_s, mis_got_s, mis_exp_s;
  logic        mis_valid_s, mis_is_mem_s, done_s, pass_s, timeout_s;
  logic [2:0]  cycle_count_s, err_count_s;

  assign zero_t = 32'h0;
  assign zero_s = 32'h0;
  assign one_s  = 32'h1;

  tb_check_ctrl dut (
    .clk(clk), .rst(rst), .halt(halt), .cpu_rst(cpu_rst),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .gold_reg_data(gold_reg_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .gold_mem_data(gold_mem_data),
    .mis_valid(mis_valid), .mis_is_mem(mis_is_mem), .mis_addr(mis_addr),
    .mis_got(mis_got), .mis_exp(mis_exp), .cycle_count(cycle_count),
    .err_count(err_count), .done(done), .pass(pass), .timeout(timeout)
  );

  tb_check_ctrl #(.NUM_WORDS(4), .MAX_CYCLES(100)) dut_t (
    .clk(clk), .rst(rst_t), .halt(halt_t), .cpu_rst(cpu_rst_t),
    .reg_rd_addr(reg_rd_addr_t), .reg_rd_data(zero_t), .gold_reg_data(zero_t),
    .mem_rd_addr(mem_rd_addr_t), .mem_rd_data(zero_t), .gold_mem_data(zero_t),
    .mis_valid(mis_valid_t), .mis_is_mem(mis_is_mem_t), .mis_addr(mis_addr_t),
    .mis_got(mis_got_t), .mis_exp(mis_exp_t), .cycle_count(cycle_count_t),
    .err_count(err_count_t), .done(done_t), .pass(pass_t), .timeout(timeout_t)
  );

  tb_check_ctrl #(.NUM_WORDS(4), .MAX_CYCLES(7), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst_s), .halt(halt_s), .cpu_rst(cpu_rst_s),
    .reg_rd_addr(reg_rd_addr_s), .reg_rd_data(one_s), .gold_reg_data(zero_s),
    .mem_rd_addr(mem_rd_addr_s), .mem_rd_data(zero_s), .gold_mem_data(zero_s),
    .mis_valid(mis_valid_s), .mis_is_mem(mis_is_mem_s), .mis_addr(mis_addr_s),
    .mis_got(mis_got_s), .mis_exp(mis_exp_s), .cycle_count(cycle_count_s),
    .err_count(err_count_s), .done(done_s), .pass(pass_s), .timeout(timeout_s)
  );

  // CPU regfile / DM and golden ROMs, one-cycle read latency
  logic [31:0] cpu_regs [32];
  logic [31:0] gold_regs [32];
  logic [31:0] dm [1024];
  logic [31:0] gold_mem [1024];
  logic [15:0] widx;
  assign widx = (mem_rd_addr - 16'h9000) >> 2;

  always @(posedge clk) begin
    reg_rd_data   <= cpu_regs[reg_rd_addr];
    gold_reg_data <= gold_regs[reg_rd_addr];
    mem_rd_data   <= dm[widx[9:0]];
    gold_mem_data <= gold_mem[widx[9:0]];
  end

  mis_t mis_log[$];
  int   sat_pulses = 0;
  always @(negedge clk) begin
    if (mis_valid === 1'b1) mis_log.push_back(mis_t'({mis_is_mem, mis_addr, mis_got, mis_exp}));
    if (mis_valid_s === 1'b1) sat_pulses++;
  end

  task automatic init_models();
    for (int i = 0; i < 32; i++) begin
      cpu_regs[i]  = 32'h1000_0000 + i * 32'h111;
      gold_regs[i] = 32'h1000_0000 + i * 32'h111;
    end
    for (int i = 0; i < 1024; i++) begin
      dm[i]       = 32'hA5A5_0000 ^ i;
      gold_mem[i] = 32'hA5A5_0000 ^ i;
    end
  endtask

  task automatic wait_done_main(input string name);
    for (int k = 0; k < 2000 && done !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done_wait: got %b expected 1", name, done); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_rst, done, pass, timeout, mis_valid} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 10000", {cpu_rst, done, pass, timeout, mis_valid});
    end
    n_checks++;
    if (cycle_count !== 20'd0 || err_count !== 20'd0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, err_count);
    end
    n_checks++;
    if (reg_rd_addr !== 5'd0 || mem_rd_addr !== 16'd0 || mis_addr !== 16'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h/%h expected 0/0/0", reg_rd_addr, mem_rd_addr, mis_addr);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL cpu_rst_hold%0d: got %b expected 1", k, cpu_rst); end
      @(negedge clk);
    end
    n_checks++;
    if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL cpu_rst_release: got %b expected 0", cpu_rst); end
    n_checks++;
    if (cycle_count !== 20'd0) begin n_fail++; $display("FAIL run_first_count: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_pass_run();
    int bad;
    int base;
    bad  = 0;
    base = mis_log.size();
    repeat (50) @(negedge clk);
    n_checks++;
    if (cycle_count !== 20'd50) begin n_fail++; $display("FAIL run_count50: got %0d expected 50", cycle_count); end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    // c counts cycles from the first DRAIN cycle: 8 drain, 33 reg, 1025 mem, then DONE
    for (int c = 0; c < 1066; c++) begin
      if (done !== 1'b0 || cpu_rst !== 1'b0) bad++;
      if (c >= 8 && c < 40 && reg_rd_addr !== 5'(c - 8)) bad++;
      if (c < 41 && mem_rd_addr !== 16'h0) bad++;
      if (c >= 41 && c < 1065 && mem_rd_addr !== 16'(32'h9000 + 4 * (c - 41))) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL sweep_sequence: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if ({done, pass, timeout, cpu_rst} !== 4'b1101) begin
      n_fail++; $display("FAIL pass_verdict: got %b expected 1101", {done, pass, timeout, cpu_rst});
    end
    n_checks++;
    if (err_count !== 20'd0 || cycle_count !== 20'd50) begin
      n_fail++; $display("FAIL pass_counts: got err %0d cyc %0d expected 0/50", err_count, cycle_count);
    end
    n_checks++;
    if (reg_rd_addr !== 5'd31 || mem_rd_addr !== 16'h9FFC) begin
      n_fail++; $display("FAIL addr_hold: got %h/%h expected 1f/9ffc", reg_rd_addr, mem_rd_addr);
    end
    n_checks++;
    if (mis_log.size() != base) begin n_fail++; $display("FAIL pass_no_mis: got %0d expected 0", mis_log.size() - base); end
  endtask

  task automatic test_mismatch();
    int base;
    cpu_regs[5] = 32'h0000_0001; gold_regs[5] = 32'h0;
    dm[4]       = 32'hDEAD_BEEF; gold_mem[4]  = 32'h0;
    rst = 1'b1;
    @(negedge clk);
    base = mis_log.size();
    n_checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rerst_from_done: got done %b cpu_rst %b expected 0/1", done, cpu_rst); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_done_main("mis");
    repeat (2) @(negedge clk);
    n_checks++;
    if (mis_log.size() - base != 2) begin n_fail++; $display("FAIL mis_pulses: got %0d expected 2", mis_log.size() - base); end
    if (mis_log.size() >= base + 2) begin
      n_checks++;
      if (mis_log[base] !== mis_t'({1'b0, 16'd5, 32'h1, 32'h0})) begin
        n_fail++; $display("FAIL mis_reg5: got %h expected %h", mis_log[base], mis_t'({1'b0, 16'd5, 32'h1, 32'h0}));
      end
      n_checks++;
      if (mis_log[base+1] !== mis_t'({1'b1, 16'h9010, 32'hDEAD_BEEF, 32'h0})) begin
        n_fail++; $display("FAIL mis_mem9010: got %h expected %h", mis_log[base+1], mis_t'({1'b1, 16'h9010, 32'hDEAD_BEEF, 32'h0}));
      end
    end
    n_checks++;
    if (err_count !== 20'd2 || pass !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL mis_verdict: got err %0d pass %b to %b expected 2/0/0", err_count, pass, timeout);
    end
  endtask

  task automatic test_abort();
    int k;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    for (k = 0; k < 2000 && mem_rd_addr !== 16'h94B0; k++) @(negedge clk);
    n_checks++;
    if (mem_rd_addr !== 16'h94B0) begin n_fail++; $display("FAIL abort_reach300: got %h expected 94b0", mem_rd_addr); end
    n_checks++;
    if (err_count !== 20'd2) begin n_fail++; $display("FAIL abort_err_before: got %0d expected 2", err_count); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cpu_rst, done} !== 2'b10 || err_count !== 20'd0 || cycle_count !== 20'd0) begin
      n_fail++; $display("FAIL abort_reset: got cpu_rst/done %b err %0d cyc %0d expected 10/0/0", {cpu_rst, done}, err_count, cycle_count);
    end
    n_checks++;
    if (mem_rd_addr !== 16'h0) begin n_fail++; $display("FAIL abort_addr_clear: got %h expected 0", mem_rd_addr); end
    cpu_regs[5] = gold_regs[5];
    dm[4]       = gold_mem[4];
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL rerun_release: got %b expected 0", cpu_rst); end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    wait_done_main("rerun");
    n_checks++;
    if (pass !== 1'b1 || err_count !== 20'd0) begin n_fail++; $display("FAIL rerun_pass: got pass %b err %0d expected 1/0", pass, err_count); end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    repeat (3) @(negedge clk);
    rst_t = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 99; k++) begin
      if (done_t !== 1'b0 || reg_rd_addr_t !== 5'd0 || mem_rd_addr_t !== 16'd0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (cycle_count_t !== 20'd99 || done_t !== 1'b0) begin
      n_fail++; $display("FAIL to_before: got cyc %0d done %b expected 99/0", cycle_count_t, done_t);
    end
    @(negedge clk);
    n_checks++;
    if ({done_t, timeout_t, pass_t, cpu_rst_t} !== 4'b1101) begin
      n_fail++; $display("FAIL to_verdict: got %b expected 1101", {done_t, timeout_t, pass_t, cpu_rst_t});
    end
    n_checks++;
    if (cycle_count_t !== 20'd100) begin n_fail++; $display("FAIL to_count: got %0d expected 100", cycle_count_t); end
    for (int k = 0; k < 10; k++) begin
      if (done_t !== 1'b1 || reg_rd_addr_t !== 5'd0 || mem_rd_addr_t !== 16'd0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL to_no_issue: got %0d bad cycles expected 0", bad); end
    // halt arriving on the limit cycle must win over the timeout
    rst_t = 1'b1;
    @(negedge clk);
    rst_t = 1'b0;
    repeat (4 + 99) @(negedge clk);
    halt_t = 1'b1;
    @(negedge clk);
    halt_t = 1'b0;
    n_checks++;
    if (done_t !== 1'b0 || timeout_t !== 1'b0 || cycle_count_t !== 20'd99) begin
      n_fail++; $display("FAIL coincide: got done %b to %b cyc %0d expected 0/0/99", done_t, timeout_t, cycle_count_t);
    end
    for (int k = 0; k < 200 && done_t !== 1'b1; k++) @(negedge clk);
    n_checks++;
    if (done_t !== 1'b1 || pass_t !== 1'b1 || timeout_t !== 1'b0) begin
      n_fail++; $display("FAIL coincide_verdict: got done %b pass %b to %b expected 1/1/0", done_t, pass_t, timeout_t);
    end
  endtask

  task automatic test_saturate();
    int p0;
    p0 = sat_pulses;
    rst_s = 1'b0;
    repeat (4) @(negedge clk);
    halt_s = 1'b1;
    @(negedge clk);
    halt_s = 1'b0;
    for (int k = 0; k < 200 && done_s !== 1'b1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_s !== 1'b1) begin n_fail++; $display("FAIL sat_done: got %b expected 1", done_s); end
    n_checks++;
    if (err_count_s !== 3'd7) begin n_fail++; $display("FAIL sat_err: got %0d expected 7", err_count_s); end
    n_checks++;
    if (sat_pulses - p0 != 32) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 32", sat_pulses - p0); end
    n_checks++;
    if (pass_s !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b expected 0", pass_s); end
  endtask

  initial begin
    init_models();
    test_reset();
    test_pass_run();
    test_mismatch();
    test_abort();
    test_timeout();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
